// File: rtl/calc_operand_entry.sv
// Keypad-to-calculator operand entry: builds a signed decimal operand from key strobes
// and commits operands/operators to the calculator with a fixed-width en pulse.
module calc_operand_entry #(
  parameter int MAX_DIGITS     = 4,
  parameter int EN_HIGH_CYCLES = 2,
  parameter int EN_LOW_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [31:0] inputval,
  output logic [2:0]  op,
  output logic        en,
  output logic        isvalid,
  output logic        busy,
  output logic [31:0] entry_val,
  output logic [2:0]  digit_count
);

  typedef enum logic [1:0] {ENTRY, SEND_HI, SEND_LO} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [13:0] mag, mag_n;
  logic        neg, neg_n;
  logic        err, err_n;
  logic [2:0]  dc_n;
  logic [31:0] inputval_n;
  logic [2:0]  op_n;
  logic        en_n;
  logic [31:0] entry_n;
  logic [13:0] mag_dig;

  // mag*10 + d as shift-add; mag <= 999 whenever a digit is accepted
  assign mag_dig = (mag << 3) + (mag << 1) + 14'(key_code);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    mag_n      = mag;
    neg_n      = neg;
    err_n      = err;
    dc_n       = digit_count;
    inputval_n = inputval;
    op_n       = op;
    en_n       = en;
    case (state)
      ENTRY: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (digit_count < 3'(MAX_DIGITS)) begin
              mag_n = mag_dig;
              dc_n  = digit_count + 3'd1;
            end else begin
              err_n = 1'b1;
            end
          end else if (key_code <= 4'd13) begin
            if (!err) begin
              inputval_n = entry_val;
              op_n       = 3'(key_code - 4'd10);
              en_n       = 1'b1;
              state_n    = SEND_HI;
              cnt_n      = 16'(EN_HIGH_CYCLES - 1);
            end
          end else if (key_code == 4'd14) begin
            err_n      = 1'b0;
            inputval_n = 32'd0;
            op_n       = 3'd4;
            en_n       = 1'b1;
            state_n    = SEND_HI;
            cnt_n      = 16'(EN_HIGH_CYCLES - 1);
          end else begin
            neg_n = ~neg;
          end
        end
      end
      SEND_HI: begin
        if (cnt == 16'd0) begin
          en_n    = 1'b0;
          state_n = SEND_LO;
          cnt_n   = 16'(EN_LOW_CYCLES - 1);
          mag_n   = 14'd0;
          neg_n   = 1'b0;
          dc_n    = 3'd0;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      SEND_LO: begin
        if (cnt == 16'd0) state_n = ENTRY;
        else              cnt_n   = cnt - 16'd1;
      end
      default: state_n = ENTRY;
    endcase
    entry_n = neg_n ? -{18'd0, mag_n} : {18'd0, mag_n};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ENTRY;
      cnt         <= 16'd0;
      mag         <= 14'd0;
      neg         <= 1'b0;
      err         <= 1'b0;
      digit_count <= 3'd0;
      inputval    <= 32'd0;
      op          <= 3'd0;
      en          <= 1'b0;
      isvalid     <= 1'b1;
      busy        <= 1'b0;
      entry_val   <= 32'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mag         <= mag_n;
      neg         <= neg_n;
      err         <= err_n;
      digit_count <= dc_n;
      inputval    <= inputval_n;
      op          <= op_n;
      en          <= en_n;
      isvalid     <= ~err_n;
      busy        <= (state_n != ENTRY);
      entry_val   <= entry_n;
    end
  end

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed plus random key streams against a cycle-level behavioural model of the entry unit.
module tb_calc_operand_entry;

  localparam int H = 2;
  localparam int L = 2;
  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        reset, key_valid;
  logic [3:0]  key_code;
  logic [31:0] inputval, entry_val;
  logic [2:0]  op, digit_count;
  logic        en, isvalid, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: magnitude as an integer, cycles elapsed since the last commit
  int m_mag = 0, m_dc = 0, m_in = 0, m_op = 0, s = 1000;
  bit m_neg = 0, m_err = 0;

  calc_operand_entry #(.MAX_DIGITS(MAXD), .EN_HIGH_CYCLES(H), .EN_LOW_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .inputval(inputval), .op(op), .en(en), .isvalid(isvalid), .busy(busy),
    .entry_val(entry_val), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_entry();
    return m_neg ? -m_mag : m_mag;
  endfunction

  task automatic model_edge(input bit rst, input bit kv, input int kc);
    if (rst) begin
      m_mag = 0; m_dc = 0; m_in = 0; m_op = 0; m_neg = 0; m_err = 0; s = 1000;
    end else if (s < H + L) begin
      if (s == H - 1) begin
        m_mag = 0; m_neg = 0; m_dc = 0;
      end
      s++;
    end else if (kv) begin
      if (kc <= 9) begin
        if (m_dc < MAXD) begin
          m_mag = m_mag * 10 + kc;
          m_dc++;
        end else m_err = 1;
      end else if (kc <= 13) begin
        if (!m_err) begin
          m_in = m_entry(); m_op = kc - 10; s = 0;
        end
      end else if (kc == 14) begin
        m_err = 0; m_in = 0; m_op = 4; s = 0;
      end else m_neg = !m_neg;
    end
  endtask

  task automatic step(input bit rst, input bit kv, input int kc);
    reset = rst; key_valid = kv; key_code = 4'(kc);
    @(posedge clk);
    model_edge(rst, kv, kc);
    @(negedge clk);
    check("en",          {31'd0, en},          {31'd0, s < H});
    check("busy",        {31'd0, busy},        {31'd0, s < H + L});
    check("inputval",    inputval,             m_in);
    check("op",          {29'd0, op},          m_op);
    check("isvalid",     {31'd0, isvalid},     {31'd0, !m_err});
    check("entry_val",   entry_val,            m_entry());
    check("digit_count", {29'd0, digit_count}, m_dc);
  endtask

  task automatic press(input int kc);
    step(0, 1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    @(negedge clk);
    step(1, 0, 0);
    check("rst_isvalid", {31'd0, isvalid}, 32'd1);
    check("rst_entry", entry_val, 32'd0);

    press(1); press(2); press(3);
    check("tp_entry123", entry_val, 32'd123);
    press(10);
    check("tp_en_hi", {31'd0, en}, 32'd1);
    check("tp_in123", inputval, 32'd123);
    idle(1);
    check("tp_en_hi2", {31'd0, en}, 32'd1);
    idle(1);
    check("tp_en_lo", {31'd0, en}, 32'd0);
    check("tp_cleared", entry_val, 32'd0);
    idle(2);
    check("tp_busy_lo", {31'd0, busy}, 32'd0);

    press(4); press(5); press(15); press(11);
    check("tp_neg45", inputval, 32'hFFFF_FFD3);
    check("tp_op_sub", {29'd0, op}, 32'd1);
    idle(4);
    press(4); press(5); press(15); press(15); press(11);
    check("tp_pos45", inputval, 32'd45);
    idle(4);

    for (int i = 0; i < 5; i++) press(9);
    check("tp_dc4", {29'd0, digit_count}, 32'd4);
    check("tp_9999", entry_val, 32'd9999);
    check("tp_err", {31'd0, isvalid}, 32'd0);
    press(12);
    check("tp_no_commit", {31'd0, en}, 32'd0);
    press(14);
    check("tp_clr_valid", {31'd0, isvalid}, 32'd1);
    check("tp_clr_op", {29'd0, op}, 32'd4);
    idle(4);

    press(7); press(12); press(3); idle(1); press(3); idle(1); press(3);
    check("tp_drop", entry_val, 32'd3);
    press(14); idle(4);

    press(8); press(13);
    step(1, 0, 0);
    check("tp_abort_en", {31'd0, en}, 32'd0);
    check("tp_abort_busy", {31'd0, busy}, 32'd0);
    idle(3);

    press(0); press(13);
    check("tp_div0", {29'd0, op}, 32'd3);
    check("tp_div0_val", inputval, 32'd0);
    idle(4);
    press(6);
    step(1, 1, 5);
    check("tp_rst_wins", entry_val, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int kc;
      kc = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, kc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
